// File: rtl/rx_chan_arbiter.sv
// N-channel receive collector: per-channel one-word holding registers, round-robin
// arbitration into a shared tagged FWFT FIFO. Optional macro RX_ARB_DROP_CNT_EN adds o_drop_cnt.

module rx_chan_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              grant,
  output logic              full,
  output logic [DATA_W-1:0] dout,
  output logic              drop
);
  logic capture;

  // A granted register empties this cycle, so it can take a new word at the same edge.
  assign capture = push && enable && (!full || grant);
  assign drop    = push && enable && full && !grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      dout <= '0;
    end else begin
      if (capture)    full <= 1'b1;
      else if (grant) full <= 1'b0;
      if (capture)    dout <= din;
    end
  end
endmodule

module rx_chan_arbiter #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_sys_clk,
  input  logic                     i_reset,
  input  logic [NUM_CH-1:0]        i_ch_enable,
  input  logic [NUM_CH-1:0]        i_ch_push,
  input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
  output logic [NUM_CH-1:0]        o_ch_full,
  output logic                     o_valid,
  output logic [DATA_W-1:0]        o_data,
  output logic [CH_W-1:0]          o_tag,
  input  logic                     i_pop,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [NUM_CH-1:0]        o_overflow,
  input  logic                     i_clear_ovf
`ifdef RX_ARB_DROP_CNT_EN
  ,
  output logic [15:0]              o_drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = CH_W + DATA_W;

  logic [NUM_CH-1:0]             hold_full;
  logic [NUM_CH-1:0][DATA_W-1:0] hold_data;
  logic [NUM_CH-1:0]             drop_vec;
  logic [NUM_CH-1:0]             grant_vec;
  logic                          grant_any;
  logic [CH_W-1:0]               grant_idx;
  logic [CH_W-1:0]               ptr;
  logic                          wr_ok;
  logic                          pop_eff;

  logic [DEPTH-1:0][EW-1:0]      mem;
  logic [AW-1:0]                 wptr, rptr;
  logic [EW-1:0]                 head;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      rx_chan_hold #(.DATA_W(DATA_W)) u_hold (
        .clk    (i_sys_clk),
        .rst    (i_reset),
        .enable (i_ch_enable[g]),
        .push   (i_ch_push[g]),
        .din    (i_ch_data[g*DATA_W +: DATA_W]),
        .grant  (grant_vec[g]),
        .full   (hold_full[g]),
        .dout   (hold_data[g]),
        .drop   (drop_vec[g])
      );
    end
  endgenerate

  assign o_ch_full = hold_full;
  assign o_valid   = (o_level != '0);
  assign pop_eff   = i_pop && o_valid;
  // At full, the write slot frees up only if the head leaves in the same cycle.
  assign wr_ok     = (o_level < LW'(DEPTH)) || ((o_level == LW'(DEPTH)) && i_pop);

  // Rotating scan starting at ptr; sum is kept one bit wider to wrap for non-power-of-two counts.
  always_comb begin
    logic [CH_W:0] sum;
    grant_any = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr} + (CH_W+1)'(i);
      if (sum >= (CH_W+1)'(NUM_CH)) sum = sum - (CH_W+1)'(NUM_CH);
      if (!grant_any && wr_ok && hold_full[sum[CH_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = sum[CH_W-1:0];
      end
    end
  end

  assign grant_vec = grant_any ? (NUM_CH'(1) << grant_idx) : '0;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset)
      ptr <= '0;
    else if (grant_any)
      ptr <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset)
      o_overflow <= '0;
    else if (i_clear_ovf)
      o_overflow <= '0;
    else
      o_overflow <= o_overflow | drop_vec;
  end

  // Storage is not reset; o_level gates every read of it.
  always_ff @(posedge i_sys_clk) begin
    if (grant_any) mem[wptr] <= {grant_idx, hold_data[grant_idx]};
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      wptr    <= '0;
      rptr    <= '0;
      o_level <= '0;
    end else begin
      if (grant_any) wptr <= wptr + 1'b1;
      if (pop_eff)   rptr <= rptr + 1'b1;
      case ({grant_any, pop_eff})
        2'b10:   o_level <= o_level + 1'b1;
        2'b01:   o_level <= o_level - 1'b1;
        default: o_level <= o_level;
      endcase
    end
  end

  assign head   = mem[rptr];
  assign o_data = o_valid ? head[DATA_W-1:0] : '0;
  assign o_tag  = o_valid ? head[EW-1:DATA_W] : '0;

`ifdef RX_ARB_DROP_CNT_EN
  logic [3:0]  ndrop;
  logic [16:0] cnt_sum;

  always_comb begin
    ndrop = '0;
    for (int k = 0; k < NUM_CH; k++) ndrop = ndrop + 4'(drop_vec[k]);
    cnt_sum = {1'b0, o_drop_cnt} + 17'(ndrop);
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset || i_clear_ovf)
      o_drop_cnt <= '0;
    else
      o_drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_rx_chan_arbiter.sv
// Randomised bench for rx_chan_arbiter: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_rx_chan_arbiter;
  localparam int NUM_CH = 3;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CH_W   = 2;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        en = '1;
  logic [NUM_CH-1:0]        push = '0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic                     pop = 1'b0;
  logic                     clr = 1'b0;
  logic [NUM_CH-1:0]        o_ch_full;
  logic                     o_valid;
  logic [DATA_W-1:0]        o_data;
  logic [CH_W-1:0]          o_tag;
  logic [LW-1:0]            o_level;
  logic [NUM_CH-1:0]        o_overflow;
`ifdef RX_ARB_DROP_CNT_EN
  logic [15:0]              o_drop_cnt;
`endif

  rx_chan_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .i_sys_clk   (clk),
    .i_reset     (rst),
    .i_ch_enable (en),
    .i_ch_push   (push),
    .i_ch_data   (ch_data),
    .o_ch_full   (o_ch_full),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_tag       (o_tag),
    .i_pop       (pop),
    .o_level     (o_level),
    .o_overflow  (o_overflow),
    .i_clear_ovf (clr)
`ifdef RX_ARB_DROP_CNT_EN
    ,
    .o_drop_cnt  (o_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: holding slots, a FIFO queue and sticky flags.
  typedef struct packed {
    logic [CH_W-1:0]   tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              q[$];
  bit [NUM_CH-1:0]   m_full;
  logic [DATA_W-1:0] m_hd[NUM_CH];
  int                m_ptr;
  bit [NUM_CH-1:0]   m_ovf;
  int                m_cnt;
  bit                started = 0;

  always @(posedge clk) begin
    int   g, ndrop;
    bit   popped, permit;
    ent_t e;
    bit [NUM_CH-1:0] setm;
    started = 1;
    if (rst) begin
      q.delete();
      m_full = '0;
      m_ptr  = 0;
      m_ovf  = '0;
      m_cnt  = 0;
    end else begin
      popped = pop && (q.size() > 0);
      permit = (q.size() < DEPTH) || popped;
      g = -1;
      if (permit)
        for (int i = 0; i < NUM_CH; i++)
          if (g < 0 && m_full[(m_ptr + i) % NUM_CH]) g = (m_ptr + i) % NUM_CH;
      if (popped) void'(q.pop_front());
      if (g >= 0) begin
        e.tag  = CH_W'(g);
        e.data = m_hd[g];
        q.push_back(e);
        m_full[g] = 1'b0;
        m_ptr = (g + 1) % NUM_CH;
      end
      ndrop = 0;
      setm  = '0;
      for (int k = 0; k < NUM_CH; k++)
        if (push[k] && en[k]) begin
          if (m_full[k]) begin
            ndrop++;
            setm[k] = 1'b1;
          end else begin
            m_full[k] = 1'b1;
            m_hd[k]   = ch_data[k*DATA_W +: DATA_W];
          end
        end
      if (clr) begin
        m_ovf = '0;
        m_cnt = 0;
      end else begin
        m_ovf = m_ovf | setm;
        m_cnt = (m_cnt + ndrop > 65535) ? 65535 : m_cnt + ndrop;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", o_valid, q.size() != 0);
      chk("level", o_level, q.size());
      if (q.size() != 0) begin
        chk("tag", o_tag, q[0].tag);
        chk("data", o_data, q[0].data);
      end
      chk("ch_full", o_ch_full, m_full);
      chk("overflow", o_overflow, m_ovf);
`ifdef RX_ARB_DROP_CNT_EN
      chk("drop_cnt", o_drop_cnt, m_cnt);
`endif
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_data(input int k, input logic [DATA_W-1:0] d);
    ch_data[k*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    // reset
    step(2);
    rst = 1'b0;
    chk("rst_valid", o_valid, 0);
    chk("rst_level", o_level, 0);
    chk("rst_full", o_ch_full, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_data", o_data, 0);

    // single word on ch1: two-cycle latency
    push = 3'b010; set_data(1, 32'h12345678);
    step();
    push = '0;
    chk("single_full1", o_ch_full, 3'b010);
    chk("single_not_yet", o_valid, 0);
    step();
    chk("single_valid", o_valid, 1);
    chk("single_tag", o_tag, 1);
    chk("single_data", o_data, 32'h12345678);
    chk("single_level", o_level, 1);
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("single_popped", o_valid, 0);

    // round robin: ch0/ch1 every cycle with pop held
    push = 3'b011; pop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_data(0, $urandom()); set_data(1, $urandom());
      step();
      if (i >= 1) begin
        chk("rr_valid", o_valid, 1);
        chk("rr_tag", o_tag, (i - 1) % 2);
      end
    end
    chk("rr_ovf", o_overflow, 3'b011);
    push = '0; clr = 1'b1;
    step();
    clr = 1'b0;
    step(20);
    chk("rr_drained", o_level, 0);
    chk("rr_cleared", o_overflow, 0);

    // full FIFO: 18 words on ch0 with no pops
    pop = 1'b0; push = 3'b001;
    for (int i = 0; i < 18; i++) begin
      set_data(0, 32'h100 + i);
      step();
    end
    push = '0;
    chk("full_level", o_level, 16);
    chk("full_hold", o_ch_full, 3'b001);
    chk("full_ovf", o_overflow, 3'b001);
`ifdef RX_ARB_DROP_CNT_EN
    chk("full_dropcnt", o_drop_cnt, 1);
`endif
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("fullpop_level", o_level, 16);
    chk("fullpop_hold", o_ch_full, 0);
    chk("fullpop_head", o_data, 32'h101);

    // clear, then disabled channel
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clear_ovf", o_overflow, 0);
`ifdef RX_ARB_DROP_CNT_EN
    chk("clear_dropcnt", o_drop_cnt, 0);
`endif
    en = 3'b101; push = 3'b010;
    step(2);
    push = '0;
    chk("dis_full", o_ch_full, 0);
    chk("dis_ovf", o_overflow, 0);
    chk("dis_level", o_level, 16);
    en = '1;

    // reset mid-stream with level 5 and both holds occupied
    pop = 1'b1;
    step(20);
    pop = 1'b0;
    push = 3'b011;
    step(6);
    chk("pre_rst_level", o_level, 5);
    chk("pre_rst_full", o_ch_full, 3'b011);
    push = '0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_level", o_level, 0);
    chk("mid_rst_full", o_ch_full, 0);
    push = 3'b011;
    step();
    push = '0;
    step();
    chk("post_rst_tag", o_tag, 0);
    pop = 1'b1;
    step(4);

    // randomised traffic; the compare process checks every cycle
    for (int seg = 0; seg < 15; seg++) begin
      int pop_pct = $urandom_range(10, 100);
      int push_pct = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        for (int k = 0; k < NUM_CH; k++) begin
          push[k] = ($urandom_range(0, 99) < push_pct);
          en[k]   = ($urandom_range(0, 9) != 0);
          set_data(k, $urandom());
        end
        pop = ($urandom_range(0, 99) < pop_pct);
        clr = ($urandom_range(0, 31) == 0);
        rst = ($urandom_range(0, 299) == 0);
        step();
      end
    end
    push = '0; pop = 1'b0; clr = 1'b0; rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
